// File: rtl/c7bicu.sv
// Instruction-cache bus interface: turns one 8-byte IFU fetch into two 32-bit
// memory reads and returns the assembled block, with flush (drop) handling.
module c7bicu (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_icu_req_ic1,
  input  logic [31:0] ifu_icu_addr_ic1,
  input  logic        ifu_icu_cancel,
  output logic        icu_ifu_ack_ic1,
  output logic        icu_ifu_data_valid_ic2,
  output logic [63:0] icu_ifu_data_ic2,
  output logic        icu_mem_req,
  output logic [31:0] icu_mem_addr,
  input  logic        mem_icu_ack,
  input  logic        mem_icu_rvalid,
  input  logic [31:0] mem_icu_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LO_REQ  = 3'd1,
    LO_WAIT = 3'd2,
    HI_REQ  = 3'd3,
    HI_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [28:0] blk_q, blk_d;
  logic [31:0] lo_q, lo_d;
  logic        drop_q, drop_d;
  logic        valid_q, valid_d;
  logic [63:0] data_q, data_d;
  logic [31:0] base_addr;
  logic [31:0] hi_addr;
  logic        unused_addr_lo;

  // The fetch is block-granular, so the byte offset within the block is dropped.
  assign unused_addr_lo = ^ifu_icu_addr_ic1[2:0];

  assign base_addr = {blk_q, 3'b000};
  assign hi_addr   = base_addr + 32'd4;

  assign icu_ifu_ack_ic1        = ifu_icu_req_ic1 & (state_q == IDLE);
  assign icu_mem_req            = (state_q == LO_REQ) | (state_q == HI_REQ);
  assign icu_ifu_data_valid_ic2 = valid_q;
  assign icu_ifu_data_ic2       = data_q;

  always_comb begin
    icu_mem_addr = 32'd0;
    if (state_q == LO_REQ) begin
      icu_mem_addr = base_addr;
    end else if (state_q == HI_REQ) begin
      icu_mem_addr = hi_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    lo_d    = lo_q;
    drop_d  = drop_q;
    valid_d = 1'b0;
    data_d  = data_q;

    if (state_q != IDLE && ifu_icu_cancel) begin
      drop_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ifu_icu_req_ic1) begin
          blk_d   = ifu_icu_addr_ic1[31:3];
          state_d = LO_REQ;
        end
      end
      LO_REQ: begin
        if (mem_icu_ack) state_d = LO_WAIT;
      end
      LO_WAIT: begin
        if (mem_icu_rvalid) begin
          lo_d    = mem_icu_rdata;
          state_d = HI_REQ;
        end
      end
      HI_REQ: begin
        if (mem_icu_ack) state_d = HI_WAIT;
      end
      HI_WAIT: begin
        // A cancel arriving with the last beat also suppresses the response.
        if (mem_icu_rvalid) begin
          state_d = RESP;
          if (!(drop_q || ifu_icu_cancel)) begin
            valid_d = 1'b1;
            data_d  = {mem_icu_rdata, lo_q};
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      blk_q   <= 29'd0;
      lo_q    <= 32'd0;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      lo_q    <= lo_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_c7bicu.sv
// Directed self-checking bench for c7bicu: fetch timing, wrap, backpressure,
// cancel handling and mid-fetch reset.
module tb_c7bicu;

  logic        clk;
  logic        reset;
  logic        ifu_icu_req_ic1;
  logic [31:0] ifu_icu_addr_ic1;
  logic        ifu_icu_cancel;
  logic        icu_ifu_ack_ic1;
  logic        icu_ifu_data_valid_ic2;
  logic [63:0] icu_ifu_data_ic2;
  logic        icu_mem_req;
  logic [31:0] icu_mem_addr;
  logic        mem_icu_ack;
  logic        mem_icu_rvalid;
  logic [31:0] mem_icu_rdata;

  int n_compared = 0;
  int n_mismatched = 0;

  c7bicu dut (
    .clk                    (clk),
    .reset                  (reset),
    .ifu_icu_req_ic1        (ifu_icu_req_ic1),
    .ifu_icu_addr_ic1       (ifu_icu_addr_ic1),
    .ifu_icu_cancel         (ifu_icu_cancel),
    .icu_ifu_ack_ic1        (icu_ifu_ack_ic1),
    .icu_ifu_data_valid_ic2 (icu_ifu_data_valid_ic2),
    .icu_ifu_data_ic2       (icu_ifu_data_ic2),
    .icu_mem_req            (icu_mem_req),
    .icu_mem_addr           (icu_mem_addr),
    .mem_icu_ack            (mem_icu_ack),
    .mem_icu_rvalid         (mem_icu_rvalid),
    .mem_icu_rdata          (mem_icu_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after each rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Entered in the LO_REQ/HI_REQ cycle; leaves at the start of the cycle after rvalid.
  task automatic memBeat(input logic [31:0] exp_addr, input logic [31:0] word,
                         input int ack_delay, input int rv_delay, input logic cancel_wait);
    for (int i = 0; i <= ack_delay; i++) begin
      mem_icu_ack = (i == ack_delay);
      #1;
      checkOutput("mem_req", {63'd0, icu_mem_req}, 64'd1);
      checkOutput("mem_addr", {32'd0, icu_mem_addr}, {32'd0, exp_addr});
      checkOutput("no_ifu_ack", {63'd0, icu_ifu_ack_ic1}, 64'd0);
      step();
    end
    mem_icu_ack    = 1'b0;
    ifu_icu_cancel = cancel_wait;
    for (int i = 0; i < rv_delay; i++) begin
      #1;
      checkOutput("mem_req_wait", {63'd0, icu_mem_req}, 64'd0);
      step();
      ifu_icu_cancel = 1'b0;
    end
    mem_icu_rvalid = 1'b1;
    mem_icu_rdata  = word;
    #1;
    checkOutput("valid_early", {63'd0, icu_ifu_data_valid_ic2}, 64'd0);
    step();
    mem_icu_rvalid = 1'b0;
    mem_icu_rdata  = 32'hDEAD_BEEF;
    ifu_icu_cancel = 1'b0;
  endtask

  // Entered in an IDLE cycle; leaves at the start of the cycle after RESP.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] lo_addr,
                               input logic [31:0] lo_word, input logic [31:0] hi_word,
                               input int lo_ack_dly, input int hi_rv_dly,
                               input logic cancel_lo, input logic cancel_now,
                               input logic hold_next, input logic [31:0] next_addr,
                               input logic exp_valid, input logic [63:0] exp_data);
    ifu_icu_req_ic1  = 1'b1;
    ifu_icu_addr_ic1 = addr;
    ifu_icu_cancel   = cancel_now;
    #1;
    checkOutput("ifu_ack", {63'd0, icu_ifu_ack_ic1}, 64'd1);
    step();
    ifu_icu_cancel   = 1'b0;
    ifu_icu_req_ic1  = hold_next;
    ifu_icu_addr_ic1 = next_addr;
    memBeat(lo_addr, lo_word, lo_ack_dly, 0, cancel_lo);
    memBeat(lo_addr + 32'd4, hi_word, 0, hi_rv_dly, 1'b0);
    #1;
    checkOutput("resp_valid", {63'd0, icu_ifu_data_valid_ic2}, {63'd0, exp_valid});
    checkOutput("resp_data", icu_ifu_data_ic2, exp_data);
    checkOutput("resp_no_ack", {63'd0, icu_ifu_ack_ic1}, 64'd0);
    step();
    #1;
    checkOutput("valid_pulse_end", {63'd0, icu_ifu_data_valid_ic2}, 64'd0);
    checkOutput("data_hold", icu_ifu_data_ic2, exp_data);
  endtask

  initial begin
    reset            = 1'b1;
    ifu_icu_req_ic1  = 1'b1;
    ifu_icu_addr_ic1 = 32'h1234_5678;
    ifu_icu_cancel   = 1'b0;
    mem_icu_ack      = 1'b0;
    mem_icu_rvalid   = 1'b0;
    mem_icu_rdata    = 32'd0;
    step();
    step();
    #1;
    checkOutput("rst_valid", {63'd0, icu_ifu_data_valid_ic2}, 64'd0);
    checkOutput("rst_data", icu_ifu_data_ic2, 64'd0);
    checkOutput("rst_mem_req", {63'd0, icu_mem_req}, 64'd0);
    checkOutput("rst_mem_addr", {32'd0, icu_mem_addr}, 64'd0);
    reset           = 1'b0;
    ifu_icu_req_ic1 = 1'b0;
    step();

    $display("[TB] zero-wait fetch");
    applyStimulus(32'h1C00_0000, 32'h1C00_0000, 32'h1111_1111, 32'h2222_2222,
                  0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 64'h2222_2222_1111_1111);

    $display("[TB] unaligned wrap");
    applyStimulus(32'hFFFF_FFFD, 32'hFFFF_FFF8, 32'hAAAA_0001, 32'hBBBB_0002,
                  0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 64'hBBBB_0002_AAAA_0001);

    $display("[TB] backpressure with held second request");
    applyStimulus(32'h0000_1234, 32'h0000_1230, 32'h0102_0304, 32'h0506_0708,
                  3, 2, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 1'b1, 64'h0506_0708_0102_0304);
    applyStimulus(32'h0000_4000, 32'h0000_4000, 32'h4444_0000, 32'h4444_0004,
                  0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 64'h4444_0004_4444_0000);

    $display("[TB] cancel in flight");
    applyStimulus(32'h2000_0040, 32'h2000_0040, 32'h9999_9999, 32'h8888_8888,
                  0, 0, 1'b1, 1'b0, 1'b1, 32'h3000_0008, 1'b0, 64'h4444_0004_4444_0000);
    applyStimulus(32'h3000_0008, 32'h3000_0008, 32'h3333_0000, 32'h3333_0004,
                  0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 64'h3333_0004_3333_0000);

    $display("[TB] cancel with request in idle");
    applyStimulus(32'h5000_0000, 32'h5000_0000, 32'h5555_0000, 32'h5555_0004,
                  0, 0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 64'h5555_0004_5555_0000);

    $display("[TB] reset mid-fetch");
    ifu_icu_req_ic1  = 1'b1;
    ifu_icu_addr_ic1 = 32'h6000_0000;
    #1;
    checkOutput("ifu_ack_rst", {63'd0, icu_ifu_ack_ic1}, 64'd1);
    step();
    ifu_icu_req_ic1 = 1'b0;
    memBeat(32'h6000_0000, 32'h6666_0000, 0, 0, 1'b0);
    mem_icu_ack = 1'b1;
    #1;
    checkOutput("hi_addr_rst", {32'd0, icu_mem_addr}, 64'h6000_0004);
    step();
    mem_icu_ack    = 1'b0;
    reset          = 1'b1;
    mem_icu_rvalid = 1'b1;
    mem_icu_rdata  = 32'h6666_0004;
    step();
    reset          = 1'b0;
    mem_icu_rvalid = 1'b0;
    #1;
    checkOutput("midrst_valid", {63'd0, icu_ifu_data_valid_ic2}, 64'd0);
    checkOutput("midrst_data", icu_ifu_data_ic2, 64'd0);
    checkOutput("midrst_mem_req", {63'd0, icu_mem_req}, 64'd0);
    checkOutput("midrst_mem_addr", {32'd0, icu_mem_addr}, 64'd0);
    step();
    #1;
    checkOutput("postrst_valid", {63'd0, icu_ifu_data_valid_ic2}, 64'd0);
    checkOutput("postrst_mem_req", {63'd0, icu_mem_req}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
